// File: rtl/imem_responder.sv
// imem_responder: instruction-memory slave for the fetch front end.
//
// A ROM-style word array answers fetch requests after a fixed LATENCY. The
// request is registered into a LATENCY-stage pipe (the array is read as the
// request enters stage 1), then lands in an in-order response FIFO whose head
// drives the response port. A credit counter caps accepted-but-unconsumed
// requests at MAX_OUTSTANDING, which also sizes the FIFO so it cannot overflow.
// flush drops everything in flight on a front-end redirect.
//
// Optional feature (macro IMEM_ACCESS_ERR_EN): misaligned or out-of-range
// fetches are still accepted but answered with resp_err=1 and a NOP word,
// without reading the array. With the macro undefined, resp_err is tied 0,
// address bits [1:0] are ignored and high address bits alias.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A valid source holds its payload until the transfer. req_ready does not
// look at req_valid. resp_data/resp_addr/resp_err hold steady while
// resp_valid=1 and resp_ready=0.
//
// Ports:
//   clk         clock
//   reset_n     synchronous active-low reset
//   req_valid   fetch request valid
//   req_ready   responder can accept a request
//   req_addr    byte address of the fetch
//   flush       discard every in-flight and queued fetch
//   resp_valid  response at FIFO head
//   resp_ready  consumer accepts the response
//   resp_data   instruction word (0 when resp_valid=0)
//   resp_addr   req_addr of the request being answered (0 when idle)
//   resp_err    access error (0 when idle)

module imem_responder #(
  parameter int    DEPTH_WORDS     = 1024,
  parameter int    LATENCY         = 2,
  parameter int    MAX_OUTSTANDING = 2,
  parameter string INIT_FILE       = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] resp_addr,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Word array. Contents are never touched by reset.
  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  logic          req_fire;
  logic          resp_fire;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [CW-1:0] count;

  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;
  assign req_ready = (count < CW'(MAX_OUTSTANDING)) && !flush;
  assign word_idx  = req_addr[AW+1:2];

`ifdef IMEM_ACCESS_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
  logic unused_bits;
  assign req_err     = 1'b0;
  assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // Credit counter: counts requests accepted but not yet consumed.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      count <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Latency pipe. Valid bits are reset/flushed; payload is free-running.
  logic        pv [LATENCY];
  logic [31:0] pa [LATENCY];
  logic [31:0] pd [LATENCY];
  logic        pe [LATENCY];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      for (int k = 0; k < LATENCY; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= req_fire;
      for (int k = 1; k < LATENCY; k++) pv[k] <= pv[k-1];
    end
  end

  // Erroneous requests never index the array; they carry a NOP instead.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pa[0] <= req_addr;
      pd[0] <= req_err ? NOP : mem[word_idx];
      pe[0] <= req_err;
    end
    for (int k = 1; k < LATENCY; k++) begin
      pa[k] <= pa[k-1];
      pd[k] <= pd[k-1];
      pe[k] <= pe[k-1];
    end
  end

  // Response FIFO, fed by whatever leaves the last pipe stage.
  logic          push;
  logic [31:0]   fd [MAX_OUTSTANDING];
  logic [31:0]   fa [MAX_OUTSTANDING];
  logic          fe [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;

  assign push = pv[LATENCY-1];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push)      wr_ptr <= next_ptr(wr_ptr);
      if (resp_fire) rd_ptr <= next_ptr(rd_ptr);
      case ({push, resp_fire})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      // The credit limit keeps the FIFO from ever overflowing.
      assert (!(push && !resp_fire && fcnt == CW'(MAX_OUTSTANDING)));
    end
  end

  // A push during flush lands in a slot that the pointer reset abandons.
  always_ff @(posedge clk) begin
    if (push) begin
      fd[wr_ptr] <= pd[LATENCY-1];
      fa[wr_ptr] <= pa[LATENCY-1];
      fe[wr_ptr] <= pe[LATENCY-1];
    end
  end

  assign resp_valid = (fcnt != '0);
  assign resp_data  = resp_valid ? fd[rd_ptr] : '0;
  assign resp_addr  = resp_valid ? fa[rd_ptr] : '0;
  assign resp_err   = resp_valid ? fe[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed steps in one initial block, a monitor
// that pushes the expected response on every accepted request and pops and
// compares it on every consumed response, and a final summary line.

module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int MAXO  = 2;
  localparam int AWB   = $clog2(DEPTH);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_err;

  logic dir_ready  = 1'b0;
  logic rand_ready = 1'b1;
  logic rand_mode  = 1'b0;

  assign resp_ready = rand_mode ? rand_ready : dir_ready;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_ready = ($urandom_range(0, 3) != 0);
  end

  imem_responder #(
    .DEPTH_WORDS    (DEPTH),
    .LATENCY        (LAT),
    .MAX_OUTSTANDING(MAXO),
    .INIT_FILE      ("")
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_addr (resp_addr),
    .resp_err  (resp_err)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [64:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {err, addr, data} for a fetch of address a.
  function automatic logic [64:0] expect_of(input logic [31:0] a);
`ifdef IMEM_ACCESS_ERR_EN
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) return {1'b1, a, 32'h0000_0013};
`endif
    return {1'b0, a, model_mem[a[AWB+1:2]]};
  endfunction

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  logic        prev_stall = 1'b0;
  logic [64:0] prev_resp  = '0;
  logic [64:0] exp_item;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", resp_valid, 1'b1);
        check("stall_hold", {resp_err, resp_addr, resp_data}, prev_resp);
      end
      if (!resp_valid) check("idle_err", resp_err, 1'b0);
      if (resp_valid && resp_ready) begin
        check("resp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          check("resp", {resp_err, resp_addr, resp_data}, exp_item);
        end
      end
      if (flush) exp_q.delete();
      else if (req_valid && req_ready) exp_q.push_back(expect_of(req_addr));
      prev_stall = resp_valid && !resp_ready && !flush;
      prev_resp  = {resp_err, resp_addr, resp_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until it is accepted.
  task automatic send(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("send_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_resp(input int bound);
    int n = 0;
    while (!resp_valid && n < bound) begin
      step();
      n++;
    end
    check("wait_resp", resp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] ra;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = $urandom;
    model_mem[0] = 32'h0050_0093;
    model_mem[1] = 32'h00a0_0113;
    model_mem[2] = 32'h0020_81b3;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = model_mem[i];
    repeat (3) step();
    reset_n = 1'b1;

    // Reset values.
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_addr", resp_addr, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_count", dut.count, 2'd0);
    check("rst_req_ready", req_ready, 1'b1);
    step();

    // Single fetch: accepted at edge 0, visible only after edge 2.
    dir_ready = 1'b1;
    send(32'h0);
    check("single_after_e0", resp_valid, 1'b0);
    step();
    check("single_after_e1", resp_valid, 1'b0);
    step();
    check("single_after_e2", resp_valid, 1'b1);
    check("single_data", resp_data, 32'h0050_0093);
    check("single_addr", resp_addr, 32'h0);
    step();
    check("single_done_valid", resp_valid, 1'b0);
    check("single_done_count", dut.count, 2'd0);

    // Streaming three fetches in order.
    send(32'h0);
    send(32'h4);
    send(32'h8);
    drain(20);
    check("stream_count", dut.count, 2'd0);

    // Backpressure: credit limit stops the third request.
    dir_ready = 1'b0;
    send(32'h0);
    send(32'h4);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    check("bp_third_blocked", req_ready, 1'b0);
    check("bp_count_full", dut.count, 2'd2);
    repeat (3) step();
    check("bp_stall_valid", resp_valid, 1'b1);
    check("bp_stall_data", resp_data, 32'h0050_0093);
    check("bp_still_blocked", req_ready, 1'b0);
    dir_ready = 1'b1;
    send(32'h8);
    drain(20);

    // Flush with the head response firing in the flush cycle.
    send(32'h0);
    send(32'h4);
    step();
    check("flush_head_valid", resp_valid, 1'b1);
    check("flush_head_data", resp_data, 32'h0050_0093);
    flush = 1'b1;
    check("flush_blocks_req", req_ready, 1'b0);
    step();
    flush = 1'b0;
    check("flush_resp_valid", resp_valid, 1'b0);
    check("flush_count", dut.count, 2'd0);
    repeat (6) step();
    check("flush_no_stale", resp_valid, 1'b0);
    send(32'h8);
    check("flush_new_e0", resp_valid, 1'b0);
    step();
    check("flush_new_e1", resp_valid, 1'b0);
    step();
    check("flush_new_e2", resp_valid, 1'b1);
    check("flush_new_data", resp_data, 32'h0020_81b3);
    drain(20);

    // Reset mid-operation with a full FIFO.
    dir_ready = 1'b0;
    send(32'h4);
    send(32'h8);
    repeat (3) step();
    check("midrst_full_valid", resp_valid, 1'b1);
    check("midrst_full_count", dut.count, 2'd2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_data", resp_data, 32'h0);
    check("midrst_resp_addr", resp_addr, 32'h0);
    check("midrst_resp_err", resp_err, 1'b0);
    check("midrst_count", dut.count, 2'd0);
    check("midrst_req_ready", req_ready, 1'b1);
    dir_ready = 1'b1;
    repeat (4) step();
    check("midrst_no_stale", resp_valid, 1'b0);
    send(32'h4);
    wait_resp(10);
    check("midrst_mem_intact", resp_data, 32'h00a0_0113);
    step();

    // Misaligned / out-of-range fetches.
`ifdef IMEM_ACCESS_ERR_EN
    send(32'h2);
    wait_resp(10);
    check("err_misaligned_err", resp_err, 1'b1);
    check("err_misaligned_data", resp_data, 32'h0000_0013);
    step();
    send(32'(4 * DEPTH));
    wait_resp(10);
    check("err_range_err", resp_err, 1'b1);
    check("err_range_addr", resp_addr, 32'(4 * DEPTH));
    step();
`else
    send(32'h2);
    wait_resp(10);
    check("alias_low_data", resp_data, 32'h0050_0093);
    check("alias_low_err", resp_err, 1'b0);
    step();
    send(32'(4 * DEPTH) + 32'h8);
    wait_resp(10);
    check("alias_high_data", resp_data, 32'h0020_81b3);
    step();
`endif
    drain(20);

    // Random fetches under random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ra = $urandom;
      else ra = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      send(ra);
    end
    drain(300);
    rand_mode = 1'b0;
    step();
    check("final_count", dut.count, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
